tlbr_cp0_sequencer: RTL and testbench

TLBR_CP0_SEQUENCER -- requirements
Module: tlbr_cp0_sequencer

---
 rtl/tlbr_cp0_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_tlbr_cp0_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlbr_cp0_sequencer.sv
// tlbr_cp0_sequencer
//   Sequences a MIPS TLBR instruction. It reads one TLB entry, then writes
//   EntryLo0, EntryLo1, PageMask and EntryHi into CP0, one register per cycle.
//   While a sequence is in flight, MFC0 reads of those registers are forwarded
//   from the captured entry.
//
//   Optional feature: define TLB_PAGEMASK_EN to include the PageMask write
//   (state WR_PM) and PageMask forwarding. The default build leaves it out:
//   the sequence is then LO0, LO1, HI, and the MASK field is never written.
//
//   Timing, with the issue cycle counted as cycle 0:
//   - READ occupies cycles 1..READ_LAT.
//   - The first CP0 write happens in cycle READ_LAT+1.
//   - done pulses in the WR_HI cycle.
//   - busy is high from READ up to, but not including, WR_HI.
//   The pipeline may release its stall there because EntryHi is the final
//   write, and it is already on the port in that cycle.
module tlbr_cp0_sequencer #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES),
    parameter int READ_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tlbr_req,
    input  logic [IDX_W-1:0] tlbr_index,
    input  logic             flush,
    output logic [IDX_W-1:0] tlb_rd_index,
    input  logic [89:0]      tlb_rd_entry,
    output logic             busy,
    output logic             done,
    output logic             cp0_we,
    output logic [4:0]       cp0_waddr,
    output logic [31:0]      cp0_wdata,
    input  logic [4:0]       fwd_rd,
    output logic             fwd_hit,
    output logic [31:0]      fwd_data
);

    // CP0 register numbers touched by TLBR
    localparam logic [4:0] RD_ENTRYLO0 = 5'd2;
    localparam logic [4:0] RD_ENTRYLO1 = 5'd3;
    localparam logic [4:0] RD_PAGEMASK = 5'd5;
    localparam logic [4:0] RD_ENTRYHI  = 5'd10;

    // Latency counter only needs to hold READ_LAT (at most 3)
    localparam int CNT_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_LO0,
        WR_LO1,
`ifdef TLB_PAGEMASK_EN
        WR_PM,
`endif
        WR_HI
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [89:0]        entry_q;
    logic               busy_q;
    logic               done_q;
    logic               we_q;
    logic [4:0]         waddr_q;
    logic [31:0]        wdata_q;

    // Formats a CP0 register image from a raw TLB entry.
    // The entry is laid out MSB first as follows:
    //   VPN2[89:71] ASID[70:63] MASK[62:51] G[50]
    //   PFN0[49:30] C0[29:27] D0[26] V0[25]
    //   PFN1[24:5]  C1[4:2]   D1[1]  V1[0]
    // Both EntryLo images take their G bit from the single shared G field.
    function automatic logic [31:0] cp0_fmt(input logic [4:0] rd, input logic [89:0] e);
        logic [31:0] r;
        r = 32'd0;
        case (rd)
            RD_ENTRYLO0: r = {6'd0, e[49:30], e[29:27], e[26], e[25], e[50]};
            RD_ENTRYLO1: r = {6'd0, e[24:5], e[4:2], e[1], e[0], e[50]};
            RD_PAGEMASK: r = {7'd0, e[62:51], 13'd0};
            RD_ENTRYHI:  r = {e[89:71], 5'd0, e[70:63]};
            default:     r = 32'd0;
        endcase
        return r;
    endfunction

    // Returns 1 for the CP0 registers this build writes, and can therefore forward
    function automatic logic is_fwd_rd(input logic [4:0] rd);
        logic r;
        r = (rd == RD_ENTRYLO0) || (rd == RD_ENTRYLO1) || (rd == RD_ENTRYHI);
`ifdef TLB_PAGEMASK_EN
        r = r || (rd == RD_PAGEMASK);
`endif
        return r;
    endfunction

    // Returns 1 while the state is one that writes CP0 from the entry register
    function automatic logic in_write_state(input state_t s);
        logic r;
        r = (s == WR_LO0) || (s == WR_LO1) || (s == WR_HI);
`ifdef TLB_PAGEMASK_EN
        r = r || (s == WR_PM);
`endif
        return r;
    endfunction

    // Sequencer FSM, with CP0 write-port and status outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            entry_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            // Write-port outputs are single-cycle unless a state below re-arms them
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (tlbr_req && !flush) begin
                        idx_q   <= tlbr_index;
                        cnt_q   <= CNT_W'(READ_LAT);
                        busy_q  <= 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            // Array data is valid this cycle. The first write is
                            // formatted straight from the bus, because entry_q is
                            // only loaded at this same edge.
                            entry_q <= tlb_rd_entry;
                            we_q    <= 1'b1;
                            waddr_q <= RD_ENTRYLO0;
                            wdata_q <= cp0_fmt(RD_ENTRYLO0, tlb_rd_entry);
                            state_q <= WR_LO0;
                        end
                    end
                end
                WR_LO0: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        we_q    <= 1'b1;
                        waddr_q <= RD_ENTRYLO1;
                        wdata_q <= cp0_fmt(RD_ENTRYLO1, entry_q);
                        state_q <= WR_LO1;
                    end
                end
                WR_LO1: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
`ifdef TLB_PAGEMASK_EN
                        we_q    <= 1'b1;
                        waddr_q <= RD_PAGEMASK;
                        wdata_q <= cp0_fmt(RD_PAGEMASK, entry_q);
                        state_q <= WR_PM;
`else
                        we_q    <= 1'b1;
                        waddr_q <= RD_ENTRYHI;
                        wdata_q <= cp0_fmt(RD_ENTRYHI, entry_q);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= WR_HI;
`endif
                    end
                end
`ifdef TLB_PAGEMASK_EN
                WR_PM: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        we_q    <= 1'b1;
                        waddr_q <= RD_ENTRYHI;
                        wdata_q <= cp0_fmt(RD_ENTRYHI, entry_q);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= WR_HI;
                    end
                end
`endif
                WR_HI: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // TLB read address: pass the issuing index through while idle, then hold the latched copy
    always_comb begin
        tlb_rd_index = idx_q;
        if (state_q == IDLE) begin
            tlb_rd_index = tlbr_index;
        end
    end

    // A flush or reset that arrives during a write cycle must kill that write immediately
    always_comb begin
        busy      = busy_q & rst_n;
        done      = done_q & rst_n & ~flush;
        cp0_we    = we_q & rst_n & ~flush;
        cp0_waddr = rst_n ? waddr_q : 5'd0;
        cp0_wdata = rst_n ? wdata_q : 32'd0;
    end

    // MFC0 forwarding from the captured entry while CP0 is being updated
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'd0;
        if (rst_n && in_write_state(state_q) && is_fwd_rd(fwd_rd)) begin
            fwd_hit  = 1'b1;
            fwd_data = cp0_fmt(fwd_rd, entry_q);
        end
    end

endmodule

// File: tb/tb_tlbr_cp0_sequencer.sv
// Testbench for tlbr_cp0_sequencer.
//   Two instances are built: u_lat1 with READ_LAT=1 and u_lat3 with READ_LAT=3.
//   Both follow the TLB_PAGEMASK_EN setting of the build.
//   Each run issues a TLBR at cycle 0 and then logs the outputs for 16 cycles.
//   The logged values are compared against hand-computed values.
module tb_tlbr_cp0_sequencer;

    logic clk;

    logic        rst_n    [2];
    logic        req      [2];
    logic [3:0]  idx_in   [2];
    logic        flush    [2];
    logic [4:0]  fwd_rd   [2];
    logic [3:0]  rd_idx   [2];
    logic [89:0] rd_entry [2];
    logic        busy     [2];
    logic        done     [2];
    logic        we       [2];
    logic [4:0]  waddr    [2];
    logic [31:0] wdata    [2];
    logic        hit      [2];
    logic [31:0] fdata    [2];

    int n_checks = 0;
    int n_errors = 0;

`ifdef TLB_PAGEMASK_EN
    localparam int NW = 4;
`else
    localparam int NW = 3;
`endif

    // Entry at index 5:
    //   VPN2=0x12345 ASID=0x3A MASK=0xFFF G=1
    //   PFN0=0xABCDE C0=3 D0=1 V0=1
    //   PFN1=0x13579 C1=2 D1=0 V1=1
    localparam logic [89:0] E5 = {19'h12345, 8'h3A, 12'hFFF, 1'b1,
                                  20'hABCDE, 3'd3, 1'b1, 1'b1,
                                  20'h13579, 3'd2, 1'b0, 1'b1};
    // Hand-computed CP0 images for E5:
    //   EntryLo0: 0xABCDE<<6 | 3<<3 | 1<<2 | 1<<1 | 1 = 0x02AF379F
    //   EntryLo1: 0x13579<<6 | 2<<3 |    0 | 1<<1 | 1 = 0x004D5E53
    //   PageMask: 0xFFF<<13                          = 0x01FFE000
    //   EntryHi:  0x12345<<13 | 0x3A                 = 0x2468A03A
    localparam logic [31:0] LO0 = 32'h02AF379F;
    localparam logic [31:0] LO1 = 32'h004D5E53;
    localparam logic [31:0] PM  = 32'h01FFE000;
    localparam logic [31:0] HI  = 32'h2468A03A;

    logic [89:0] mem [16];
    logic [89:0] pipe_l1;
    logic [89:0] pipe_l3 [3];

    // Per-cycle logs of one run
    logic        we_log   [16];
    logic [4:0]  addr_log [16];
    logic [31:0] data_log [16];
    logic        done_log [16];
    logic        busy_log [16];
    logic        hit_log  [16];
    logic [31:0] fd_log   [16];
    logic [3:0]  ridx_log [16];
    logic [4:0]  fwd_sched [16];
    int nwr, ndone, first_we, done_cyc;

    tlbr_cp0_sequencer #(.TLB_ENTRIES(16), .READ_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n[0]), .tlbr_req(req[0]), .tlbr_index(idx_in[0]),
        .flush(flush[0]), .tlb_rd_index(rd_idx[0]), .tlb_rd_entry(rd_entry[0]),
        .busy(busy[0]), .done(done[0]), .cp0_we(we[0]), .cp0_waddr(waddr[0]),
        .cp0_wdata(wdata[0]), .fwd_rd(fwd_rd[0]), .fwd_hit(hit[0]), .fwd_data(fdata[0])
    );

    tlbr_cp0_sequencer #(.TLB_ENTRIES(16), .READ_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n[1]), .tlbr_req(req[1]), .tlbr_index(idx_in[1]),
        .flush(flush[1]), .tlb_rd_index(rd_idx[1]), .tlb_rd_entry(rd_entry[1]),
        .busy(busy[1]), .done(done[1]), .cp0_we(we[1]), .cp0_waddr(waddr[1]),
        .cp0_wdata(wdata[1]), .fwd_rd(fwd_rd[1]), .fwd_hit(hit[1]), .fwd_data(fdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TLB array model: a synchronous read that is READ_LAT registers deep
    always @(posedge clk) begin
        pipe_l1    <= mem[rd_idx[0]];
        pipe_l3[0] <= mem[rd_idx[1]];
        pipe_l3[1] <= pipe_l3[0];
        pipe_l3[2] <= pipe_l3[1];
    end
    assign rd_entry[0] = pipe_l1;
    assign rd_entry[1] = pipe_l3[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues a TLBR at cycle 0 and logs cycles 0..15.
    // A cycle number of -1 disables the flush, the second request and the reset.
    // Must be entered 1 time unit after a rising edge.
    task automatic run_seq(input int d, input logic [3:0] idx, input int flush_cyc,
                           input int req2_cyc, input int rst_cyc);
        req[d]    = 1'b1;
        idx_in[d] = idx;
        flush[d]  = 1'b0;
        fwd_rd[d] = fwd_sched[0];
        for (int c = 0; c < 16; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                req[d]    = (c == req2_cyc);
                idx_in[d] = (c == req2_cyc) ? 4'd9 : idx;
                flush[d]  = (c == flush_cyc);
                rst_n[d]  = (c != rst_cyc);
                fwd_rd[d] = fwd_sched[c];
            end
            @(negedge clk);
            we_log[c]   = we[d];
            addr_log[c] = waddr[d];
            data_log[c] = wdata[d];
            done_log[c] = done[d];
            busy_log[c] = busy[d];
            hit_log[c]  = hit[d];
            fd_log[c]   = fdata[d];
            ridx_log[c] = rd_idx[d];
        end
        @(posedge clk);
        #1;
        req[d]    = 1'b0;
        flush[d]  = 1'b0;
        rst_n[d]  = 1'b1;
        fwd_rd[d] = 5'd0;
        nwr = 0; ndone = 0; first_we = -1; done_cyc = -1;
        for (int c = 0; c < 16; c++) begin
            if (we_log[c]) begin
                nwr++;
                if (first_we < 0) first_we = c;
            end
            if (done_log[c]) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        for (int c = 0; c < 16; c++) fwd_sched[c] = 5'd0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 90'd0;
        mem[5] = E5;
        mem[9] = ~E5;
        for (int c = 0; c < 16; c++) fwd_sched[c] = 5'd0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req[d] = 1'b0; idx_in[d] = 4'd0;
            flush[d] = 1'b0; fwd_rd[d] = 5'd10;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  {31'd0, busy[0]}, 32'd0);
        chk("rst_done",  {31'd0, done[0]}, 32'd0);
        chk("rst_we",    {31'd0, we[0]},   32'd0);
        chk("rst_waddr", {27'd0, waddr[0]}, 32'd0);
        chk("rst_wdata", wdata[0], 32'd0);
        chk("rst_hit",   {31'd0, hit[0]},  32'd0);
        chk("rst_fdata", fdata[0], 32'd0);
        chk("rst_busy3", {31'd0, busy[1]}, 32'd0);
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        fwd_rd[0] = 5'd0; fwd_rd[1] = 5'd0;
        @(posedge clk);
        #1;

        // Full sequence with READ_LAT=1, and forwarding probes
        fwd_sched[2] = 5'd10;
        fwd_sched[3] = 5'd4;
        fwd_sched[4] = 5'd5;
        run_seq(0, 4'd5, -1, -1, -1);
        chk("l1_rdidx",   {28'd0, ridx_log[1]}, 32'd5);
        chk("l1_idle_c0", {31'd0, busy_log[0]}, 32'd0);
        chk("l1_first",   first_we, 2);
        chk("l1_nwr",     nwr, NW);
        chk("l1_ndone",   ndone, 1);
        chk("l1_donecyc", done_cyc, 1 + NW);
        chk("l1_a_lo0",   {27'd0, addr_log[2]}, 32'd2);
        chk("l1_d_lo0",   data_log[2], LO0);
        chk("l1_a_lo1",   {27'd0, addr_log[3]}, 32'd3);
        chk("l1_d_lo1",   data_log[3], LO1);
`ifdef TLB_PAGEMASK_EN
        chk("l1_a_pm",    {27'd0, addr_log[4]}, 32'd5);
        chk("l1_d_pm",    data_log[4], PM);
        chk("l1_fwd5hit", {31'd0, hit_log[4]}, 32'd1);
        chk("l1_fwd5dat", fd_log[4], PM);
`else
        chk("l1_fwd5hit", {31'd0, hit_log[4]}, 32'd0);
        chk("l1_fwd5dat", fd_log[4], 32'd0);
`endif
        chk("l1_a_hi",    {27'd0, addr_log[1 + NW]}, 32'd10);
        chk("l1_d_hi",    data_log[1 + NW], HI);
        chk("l1_fwd10hit", {31'd0, hit_log[2]}, 32'd1);
        chk("l1_fwd10dat", fd_log[2], HI);
        chk("l1_fwd4hit", {31'd0, hit_log[3]}, 32'd0);
        chk("l1_fwd4dat", fd_log[3], 32'd0);
        for (int c = 1; c < 1 + NW; c++)
            chk($sformatf("l1_busy_c%0d", c), {31'd0, busy_log[c]}, 32'd1);
        chk("l1_busy_hi",   {31'd0, busy_log[1 + NW]}, 32'd0);
        chk("l1_busy_after", {31'd0, busy_log[2 + NW]}, 32'd0);

        // READ_LAT=3: reads occupy cycles 1..3
        run_seq(1, 4'd5, -1, -1, -1);
        chk("l3_rdidx3",  {28'd0, ridx_log[3]}, 32'd5);
        chk("l3_first",   first_we, 4);
        chk("l3_d_lo0",   data_log[4], LO0);
        chk("l3_nwr",     nwr, NW);
        chk("l3_donecyc", done_cyc, 3 + NW);
        chk("l3_d_hi",    data_log[3 + NW], HI);
        for (int c = 1; c < 3 + NW; c++)
            chk($sformatf("l3_busy_c%0d", c), {31'd0, busy_log[c]}, 32'd1);
        chk("l3_busy_hi", {31'd0, busy_log[3 + NW]}, 32'd0);

        // Flush during the WR_LO1 cycle (cycle 3)
        run_seq(0, 4'd5, 3, -1, -1);
        chk("fl_nwr",    nwr, 1);
        chk("fl_addr",   {27'd0, addr_log[2]}, 32'd2);
        chk("fl_we_c3",  {31'd0, we_log[3]}, 32'd0);
        chk("fl_ndone",  ndone, 0);
        chk("fl_busy_c4", {31'd0, busy_log[4]}, 32'd0);

        // A second request during WR_LO0 is ignored
        run_seq(0, 4'd5, -1, 2, -1);
        chk("rq2_nwr",   nwr, NW);
        chk("rq2_ndone", ndone, 1);
        chk("rq2_d_hi",  data_log[1 + NW], HI);

        // Reset during the WR_LO1 cycle aborts the sequence, like a flush
        run_seq(0, 4'd5, -1, -1, 3);
        chk("rs_nwr",    nwr, 1);
        chk("rs_we_c3",  {31'd0, we_log[3]}, 32'd0);
        chk("rs_ndone",  ndone, 0);
        chk("rs_busy_c4", {31'd0, busy_log[4]}, 32'd0);

        // Sequencer recovers cleanly after the reset abort
        run_seq(0, 4'd5, -1, -1, -1);
        chk("rc_nwr",    nwr, NW);
        chk("rc_d_lo0",  data_log[2], LO0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
